msg_sched_sequencer: RTL and testbench
======================================

MSG_SCHED_SEQUENCER -- requirements
Module: msg_sched_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  Sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  Asynchronous active-low reset.
REQ-004 start  input  1  Request to begin scheduling message_block; sampled only in IDLE.
REQ-005 abort  input  1  Terminate current schedule; sampled in RUN.
REQ-006 message_block  input  [0:511]  Padded 512-bit block; bits [0:31] = W[0], [32:63] = W[1], ..., [480:511] = W[15].
REQ-007 w_ready  input  1  Consumer (compression round) accepts w_data this cycle.
REQ-008 w_valid  output  1  w_data/w_index hold a valid schedule word.
REQ-009 w_data  output  [0:31]  Current schedule word W[t], bit 0 = MSB.
REQ-010 w_index  output  [5:0]  Current round index t, 0..63.
REQ-011 busy  output  1  High whenever the state is not IDLE.
REQ-012 done  output  1  One-cycle pulse after W[63] is accepted.

Function
REQ-013 The FSM SHALL have states IDLE, RUN and DONE.
REQ-014 IDLE + start=1: load message_block into a 16-word window win[0..15] (win[i] = W[i]), set t=0, go to RUN; W[0] SHALL appear on w_data with w_valid=1 in the cycle after start is sampled.
REQ-015 In RUN: w_valid=1, w_data=win[0], w_index=t.
REQ-016 Handshake = w_valid & w_ready. On a handshake with t<63: shift the window (win[i] <= win[i+1], i=0..14), set win[15] <= new word, t <= t+1.
REQ-017 New word = sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0], modulo 2^32 (carries out of bit 0 discarded); this equals W[t+16].
REQ-018 sigma0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x).
REQ-019 sigma1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
REQ-020 Without a handshake, w_data, w_index, w_valid and the window SHALL hold stable (no loss or duplication under backpressure, including w_ready=0 for arbitrary cycles).
REQ-021 A handshake at t=63 SHALL move the FSM to DONE; DONE drives done=1 and w_valid=0 for exactly one cycle, then returns to IDLE.
REQ-022 Throughput: with w_ready held at 1, W[0]..W[63] SHALL be emitted on 64 consecutive cycles.
REQ-023 start asserted in RUN or DONE SHALL be ignored (no reload, no effect on t).
REQ-024 abort=1 in RUN SHALL return the FSM to IDLE on the next edge, with w_valid=0, no done pulse, and the window contents don't-care; abort takes priority over a simultaneous handshake.
REQ-025 abort in IDLE or DONE SHALL be ignored; in IDLE, start=1 with abort=1 SHALL still start a schedule.
REQ-026 message_block SHALL be sampled only on the start edge; later changes SHALL NOT affect the schedule in progress.
REQ-027 The block SHALL complete a second start in the cycle after DONE without residual state from the prior block.

Reset
REQ-028 rst_n=0 SHALL immediately force state=IDLE, t=0, w_valid=0, done=0, busy=0, w_index=0 and w_data=0, independent of clk.
REQ-029 Reset asserted mid-RUN SHALL abandon the schedule; after release the block SHALL wait in IDLE for a new start.
REQ-030 All window registers SHALL reset to 0.

Verification
REQ-031 "abc" block (W[0]=0x61626380, W[1..14]=0, W[15]=0x00000018), start, w_ready=1 -> W[16]=0x61626380, W[17]=0x000F0000; 64 consecutive valid cycles; done 1 cycle after W[63] is accepted.
REQ-032 Same block, w_ready toggled pseudo-randomly -> identical 64-word sequence to a reference model; w_data stable while w_valid & !w_ready.
REQ-033 abort at t=20 -> w_valid=0 next cycle, busy=0, no done; a following start reproduces W[0] of the new block.
REQ-034 rst_n pulsed low at t=40 without a clock edge -> outputs immediately at reset values; restart completes normally.
REQ-035 start pulsed at t=10 with a different message_block -> sequence unaffected; back-to-back start in the cycle after done -> new schedule begins with no gap error.
REQ-036 All-ones block (every W[0..15]=0xFFFFFFFF) -> verify modulo-2^32 wrap of W[16..63] against the model.

Source files
------------

// File: rtl/msg_sched_sequencer.sv
// Message schedule sequencer: loads a 512-bit padded block and streams the
// 64 schedule words W[0..63] over a valid/ready handshake, one per round.
module msg_sched_sequencer (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    input  logic [0:511] message_block,
    input  logic         w_ready,
    output logic         w_valid,
    output logic [0:31]  w_data,
    output logic [5:0]   w_index,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] win [16];
    logic [5:0]  t_q;
    logic        load;
    logic        shift;
    logic [31:0] new_word;

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    // Window taps: win[14]=W[t+14], win[9]=W[t+9], win[1]=W[t+1], win[0]=W[t]
    assign new_word = sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, datapath controls and outputs; abort wins over a handshake
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        shift   = 1'b0;
        w_valid = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                w_valid = 1'b1;
                busy    = 1'b1;
                if (abort) begin
                    state_d = IDLE;
                end else if (w_ready) begin
                    if (t_q == 6'd63) begin
                        state_d = DONE;
                    end else begin
                        shift = 1'b1;
                    end
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Window and round counter: load on start, shift on each accepted word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 16; i++) begin
                win[i] <= '0;
            end
            t_q <= '0;
        end else if (load) begin
            for (int unsigned i = 0; i < 16; i++) begin
                win[i] <= message_block[32*i +: 32];
            end
            t_q <= '0;
        end else if (shift) begin
            for (int unsigned i = 0; i < 15; i++) begin
                win[i] <= win[i+1];
            end
            win[15] <= new_word;
            t_q     <= t_q + 6'd1;
        end
    end

    assign w_data  = win[0];
    assign w_index = t_q;

endmodule

// File: tb/tb_msg_sched_sequencer.sv
// Directed bench for msg_sched_sequencer with a reference schedule model
// feeding an expected-word queue that is drained on each handshake.
module tb_msg_sched_sequencer;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         abort;
    logic [0:511] message_block;
    logic         w_ready;
    logic         w_valid;
    logic [0:31]  w_data;
    logic [5:0]   w_index;
    logic         busy;
    logic         done;

    int unsigned  total = 0;
    int unsigned  bad   = 0;
    logic [31:0]  exp_q [$];
    int           exp_idx;
    int           ncyc;
    logic [0:511] abc_blk, ones_blk, alt_blk, rnd_blk;

    msg_sched_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .abort         (abort),
        .message_block (message_block),
        .w_ready       (w_ready),
        .w_valid       (w_valid),
        .w_data        (w_data),
        .w_index       (w_index),
        .busy          (busy),
        .done          (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Push the full 64-word reference schedule for blk
    task automatic push_model(input logic [0:511] blk);
        logic [31:0] w [64];
        for (int i = 0; i < 16; i++) w[i] = blk[32*i +: 32];
        for (int i = 16; i < 64; i++)
            w[i] = s1(w[i-2]) + w[i-7] + s0(w[i-15]) + w[i-16];
        exp_q.delete();
        for (int i = 0; i < 64; i++) exp_q.push_back(w[i]);
        exp_idx = 0;
    endtask

    // Start from IDLE; message_block is scrambled afterwards to prove it is sampled once
    task automatic do_start(input logic [0:511] blk, input logic ab);
        message_block = blk;
        start = 1'b1;
        abort = ab;
        push_model(blk);
        cycle();
        start = 1'b0;
        abort = 1'b0;
        message_block = ~blk;
    endtask

    // mode 0: always ready, 1: random ready. Stops early when exp_idx hits stop_at.
    task automatic consume(input int mode, input int stop_at, input int pulse_at, input bit abc_chk,
                           output int cycles);
        cycles = 0;
        while (exp_q.size() > 0) begin
            if (exp_idx == stop_at) return;
            if (cycles >= 2000) begin
                chk("timeout", 64'd1, 64'd0);
                exp_q.delete();
                break;
            end
            w_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (exp_idx == pulse_at) begin
                start = 1'b1;
                message_block = alt_blk;
            end else begin
                start = 1'b0;
            end
            chk("valid", 64'(w_valid), 64'd1);
            chk("data", 64'(w_data), 64'(exp_q[0]));
            chk("index", 64'(w_index), 64'(exp_idx));
            if (abc_chk && exp_idx == 16) chk("abc_w16", 64'(w_data), 64'h61626380);
            if (abc_chk && exp_idx == 17) chk("abc_w17", 64'(w_data), 64'h000F0000);
            if (w_ready && w_valid) begin
                void'(exp_q.pop_front());
                exp_idx++;
            end
            cycle();
            cycles++;
        end
        w_ready = 1'b0;
        start = 1'b0;
    endtask

    task automatic check_done_pulse();
        chk("done_hi", 64'(done), 64'd1);
        chk("done_valid_lo", 64'(w_valid), 64'd0);
        chk("done_busy", 64'(busy), 64'd1);
        cycle();
        chk("done_lo", 64'(done), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        w_ready = 1'b0;
        message_block = '0;
        abc_blk = '0;
        abc_blk[0:31] = 32'h61626380;
        abc_blk[480:511] = 32'h00000018;
        ones_blk = '1;
        for (int i = 0; i < 16; i++) begin
            alt_blk[32*i +: 32] = 32'hA5A50000 + 32'(i);
            rnd_blk[32*i +: 32] = $urandom;
        end

        // Reset values
        #1;
        chk("rst_valid", 64'(w_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_index", 64'(w_index), 64'd0);
        chk("rst_data", 64'(w_data), 64'd0);
        cycle();
        rst_n = 1'b1;
        cycle();

        // abc, full throughput, stray start at t=10
        do_start(abc_blk, 1'b0);
        consume(0, -1, 10, 1'b1, ncyc);
        chk("consecutive", 64'(ncyc), 64'd64);
        start = 1'b1;
        message_block = alt_blk;
        chk("done_hi", 64'(done), 64'd1);
        cycle();
        start = 1'b0;
        chk("start_in_done_ignored", 64'(busy), 64'd0);

        // back-to-back start, random backpressure
        do_start(abc_blk, 1'b0);
        consume(1, -1, -1, 1'b1, ncyc);
        check_done_pulse();

        // abort at t=20
        do_start(ones_blk, 1'b0);
        consume(0, 20, -1, 1'b0, ncyc);
        abort = 1'b1;
        w_ready = 1'b1;
        cycle();
        abort = 1'b0;
        w_ready = 1'b0;
        exp_q.delete();
        chk("abort_valid", 64'(w_valid), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        cycle();
        chk("abort_no_done", 64'(done), 64'd0);

        // all-ones wrap, random backpressure
        do_start(ones_blk, 1'b0);
        consume(1, -1, -1, 1'b0, ncyc);
        check_done_pulse();

        // asynchronous reset mid-run at t=40
        do_start(rnd_blk, 1'b0);
        consume(0, 40, -1, 1'b0, ncyc);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(w_valid), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        chk("arst_index", 64'(w_index), 64'd0);
        chk("arst_data", 64'(w_data), 64'd0);
        #1 rst_n = 1'b1;
        exp_q.delete();
        w_ready = 1'b1;
        cycle();
        cycle();
        chk("post_rst_idle", 64'(busy), 64'd0);
        chk("post_rst_valid", 64'(w_valid), 64'd0);

        // restart with start and abort together in IDLE
        do_start(abc_blk, 1'b1);
        consume(0, -1, -1, 1'b1, ncyc);
        chk("restart_consecutive", 64'(ncyc), 64'd64);
        check_done_pulse();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "global timeout");
    end

endmodule
